mult_seq_param: RTL and testbench
=================================

// Module: mult_seq_param
// PURPOSE
//   Parametrised sequential shift-add multiplier with a valid/done/ack handshake.
//   Next generation of the team's fixed 32-bit multiplier:
//   - operand width set by parameter; fixed, documented latency
//   - explicit busy indication
//   - optional signed mode, compiled in with a macro
//   Sits between an operand producer (valid_data) and a consumer that
//   acknowledges each result (ack).
// PARAMETERS
//   WIDTH  32  operand width in bits (>=2); the product is 2*WIDTH bits wide
// PORTS
//   clk         in   1          rising-edge clock
//   reset       in   1          asynchronous, active-low reset (0 = reset)
//   a           in   WIDTH      multiplicand; sampled only on the capture edge
//   b           in   WIDTH      multiplier; sampled only on the capture edge
//   valid_data  in   1          operand request; honoured only in IDLE
//   ack         in   1          consumer has taken producto; honoured only in DONE
//   signed_op   in   1          present only with MULT_SIGNED_EN: 1 = two's-complement operands
//   producto    out  2*WIDTH    product, registered
//   Done_Flag   out  1          result valid; held high until ack is sampled
//   busy        out  1          high in CALC and in DONE
// BEHAVIOUR
//   Reset (reset=0, asynchronous): state=IDLE, producto=0, Done_Flag=0, busy=0;
//     internal operand, accumulator and counter registers are cleared.
//   States: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: when valid_data=1 at edge E0, latch a, b (and signed_op), clear the
//     accumulator, set counter=WIDTH, go to CALC, busy=1 after E0.
//   CALC: one shift-add step per edge, LSB of the multiplier first
//     (if the LSB is 1, add the multiplicand to the upper half; shift right).
//     The counter decrements each step. At edge E0+WIDTH: producto<=result,
//     Done_Flag=1, go to DONE.
//   Latency: Done_Flag rises exactly WIDTH cycles after the capture edge,
//     independent of operand values.
//   DONE: producto and Done_Flag are stable until ack=1 is sampled. On that
//     edge: Done_Flag=0, busy=0, go to IDLE. producto keeps its last value.
//   Arithmetic: unsigned result is exact: (2^W-1)^2 fits in 2W bits, no
//     truncation.
//   Boundary and simultaneous-event rules:
//   - valid_data in CALC or DONE is ignored; operands are not re-sampled.
//   - valid_data=1 and ack=1 on the same DONE edge: ack is taken, state goes
//     to IDLE, and no new capture happens that edge. The next capture is at
//     the earliest one edge later.
//   - ack in IDLE or CALC has no effect.
//   - Back-to-back: valid_data held high gives one operation per WIDTH+2
//     cycles (capture, WIDTH steps, ack edge, IDLE edge).
//   - Zero operand: runs the full WIDTH steps; producto=0.
//   - reset asserted mid-CALC or in DONE: immediate abort, all outputs to
//     their reset values; the pending result is lost.
// CONFIGURATION
//   MULT_SIGNED_EN defined:
//   - adds the signed_op port.
//   - signed_op=1: the core multiplies the operand magnitudes; the final CALC
//     step negates the result if sign(a) XOR sign(b).
//   - latency is unchanged (WIDTH).
//   - -2^(W-1) * -2^(W-1) = 2^(2W-2) is represented exactly.
//   - signed_op=0: behaves exactly as unsigned.
//   MULT_SIGNED_EN undefined: no signed_op port; all operands are unsigned.
// TESTING (WIDTH=32 unless stated)
//   1. reset low 20ns, then high; a=32, b=3, valid_data=1
//      -> Done_Flag high 32 cycles after capture, producto=96, busy=1 until
//      the ack edge.
//   2. a=5, b=5; delay ack by 7 cycles after Done_Flag
//      -> producto=25 and Done_Flag stay stable throughout the 7 cycles;
//      both drop/hold correctly one edge after ack.
//   3. a=b=32'hFFFFFFFF -> producto=64'hFFFFFFFE00000001; a=0, b=123 ->
//      producto=0 with the same 32-cycle latency.
//   4. valid_data and ack both high on the DONE edge; change a/b during CALC
//      -> exactly one capture per operation; results use the latched operands.
//   5. reset pulsed low at CALC step 10 -> Done_Flag=0, busy=0,
//      producto=0 immediately; a new request afterwards completes normally.
//   6. MULT_SIGNED_EN, WIDTH=8, signed_op=1:
//      -3*7 -> 16'hFFEB; -128*-128 -> 16'h4000; signed_op=0, 8'hFD*7 -> 16'h06EB.

Source files
------------

// File: rtl/mult_seq_param_if.sv
// Operand/result bundle for mult_seq_param: producer side drives operands and ack,
// multiplier side returns the product and status. signed_op exists only with MULT_SIGNED_EN.
interface mult_seq_param_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               valid_data;
  logic               ack;
`ifdef MULT_SIGNED_EN
  logic               signed_op;
`endif
  logic [2*WIDTH-1:0] producto;
  logic               Done_Flag;
  logic               busy;

  modport master (
    output a, b, valid_data, ack,
`ifdef MULT_SIGNED_EN
    output signed_op,
`endif
    input  producto, Done_Flag, busy
  );

  modport slave (
    input  a, b, valid_data, ack,
`ifdef MULT_SIGNED_EN
    input  signed_op,
`endif
    output producto, Done_Flag, busy
  );
endinterface

// File: rtl/mult_seq_param.sv
// Sequential shift-add multiplier, fixed WIDTH-cycle latency, valid/done/ack handshake.
// Define MULT_SIGNED_EN to add the signed_op input (sign-magnitude two's-complement mode).
module mult_seq_param #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  mult_seq_param_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] producto_q;
  logic               done_q;
  logic               busy_q;

  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH-1:0]   mag_b_d;
  logic               neg_d;
  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] step_d;
  logic [2*WIDTH-1:0] result_d;

  // The core always works on magnitudes; the sign is reapplied on the last step.
  always_comb begin
`ifdef MULT_SIGNED_EN
    neg_d   = bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    mag_a_d = (bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b_d = (bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
`else
    neg_d   = 1'b0;
    mag_a_d = bus.a;
    mag_b_d = bus.b;
`endif
  end

  // lo_q holds the unconsumed multiplier bits; product bits shift in from the top.
  always_comb begin
    sum_d    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    step_d   = {sum_d, lo_q[WIDTH-1:1]};
    result_d = neg_q ? -step_d : step_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      producto_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_data) begin
            mcand_q <= mag_a_d;
            lo_q    <= mag_b_d;
            hi_q    <= '0;
            neg_q   <= neg_d;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          {hi_q, lo_q} <= step_d;
          cnt_q        <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            producto_q <= result_d;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (bus.ack) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.producto  = producto_q;
  assign bus.Done_Flag = done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult_seq_param.sv
// Scoreboard bench for mult_seq_param: the driver pushes reference products at capture,
// an independent monitor pops and checks them when Done_Flag rises.
module tb_mult_seq_param;

  localparam int W  = 32;
  localparam int PW = 2 * W;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mult_seq_param_if #(.WIDTH(W)) bus ();

  mult_seq_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PW-1:0] prod;
    int unsigned   cap;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec   = 0;
  int   n_check = 0;
  int   n_err   = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_check++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer multiplication of the operands as interpreted numbers.
  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sop);
    logic signed [PW-1:0] sa, sb;
    logic [PW-1:0] ua, ub;
    if (sop) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    return ua * ub;
  endfunction

  // Monitor: checks product and latency on the rising Done_Flag, stability while held.
  logic          done_prev = 1'b0;
  logic [PW-1:0] held_prod = '0;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      done_prev = 1'b0;
    end else begin
      if (bus.Done_Flag && !done_prev) begin
        if (sb_q.size() == 0) begin
          n_check++;
          n_err++;
          $display("FAIL unexpected_done: got Done_Flag=1, expected no pending result");
        end else begin
          mon_e = sb_q.pop_front();
          check("product", bus.producto, mon_e.prod);
          check("latency", PW'(cyc - mon_e.cap), PW'(W));
          check("busy_done", PW'(bus.busy), PW'(1));
        end
        held_prod = bus.producto;
      end else if (bus.Done_Flag) begin
        check("hold_product", bus.producto, held_prod);
      end
      done_prev = bus.Done_Flag;
    end
  end

  task automatic set_sop(input logic sop);
`ifdef MULT_SIGNED_EN
    bus.signed_op = sop;
`else
    if (sop) $display("note: signed_op ignored in unsigned build");
`endif
  endtask

  // One operation starting at a negedge with the DUT idle; ends at a negedge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sop,
                       input int ack_dly, input logic keep_valid, input logic ack_in_calc);
    logic          eff_sop;
    logic [PW-1:0] exp;
    logic          got;
`ifdef MULT_SIGNED_EN
    eff_sop = sop;
`else
    eff_sop = 1'b0;
`endif
    exp = model(a, b, eff_sop);
    bus.a = a;
    bus.b = b;
    set_sop(eff_sop);
    bus.valid_data = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back('{exp, cyc});
    n_vec++;
    $display("op %0d: a=%h b=%h signed=%0b ack_dly=%0d expect=%h",
             n_vec, a, b, eff_sop, ack_dly, exp);
    @(negedge clk);
    check("busy_calc", PW'(bus.busy), PW'(1));
    check("done_calc", PW'(bus.Done_Flag), PW'(0));
    // Operands changing and valid/ack asserted during CALC must be ignored.
    bus.a = $urandom;
    bus.b = $urandom;
    set_sop($urandom_range(0, 1) == 1);
    bus.valid_data = keep_valid;
    if (ack_in_calc) bus.ack = 1'b1;
    got = 1'b0;
    for (int i = 0; i < W + 4 && !got; i++) begin
      if (i == 3) bus.ack = 1'b0;
      @(negedge clk);
      got = bus.Done_Flag;
    end
    bus.ack = 1'b0;
    if (!got) begin
      n_check++;
      n_err++;
      $display("FAIL done_timeout: got no Done_Flag within %0d cycles, expected %0d", W + 4, W);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      sb_q.delete();
      bus.valid_data = 1'b0;
      return;
    end
    repeat (ack_dly) @(negedge clk);
    check("done_before_ack", PW'(bus.Done_Flag), PW'(1));
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    check("done_after_ack", PW'(bus.Done_Flag), PW'(0));
    check("busy_after_ack", PW'(bus.busy), PW'(0));
    check("product_kept", bus.producto, exp);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         keep;
    bus.a = '0;
    bus.b = '0;
    bus.valid_data = 1'b0;
    bus.ack = 1'b0;
    set_sop(1'b0);
    reset = 1'b0;
    #15;
    check("reset_producto", bus.producto, '0);
    check("reset_done", PW'(bus.Done_Flag), PW'(0));
    check("reset_busy", PW'(bus.busy), PW'(0));
    #5 reset = 1'b1;
    @(negedge clk);

    do_op(32'd32, 32'd3, 1'b0, 0, 1'b0, 1'b0);
    do_op(32'd5, 32'd5, 1'b0, 7, 1'b0, 1'b1);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1, 1'b0, 1'b0);
    do_op(32'd0, 32'd123, 1'b0, 0, 1'b0, 1'b0);
    do_op(32'd1, 32'd0, 1'b0, 0, 1'b0, 1'b0);

    // valid_data held through the ack edge: one capture per operation only.
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0, 1'b1, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 2, 1'b1, 1'b0);
    do_op(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 0, 1'b0, 1'b0);

`ifdef MULT_SIGNED_EN
    do_op(-32'sd3, 32'd7, 1'b1, 0, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFD, 32'd7, 1'b0, 0, 1'b0, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0, 1'b0, 1'b0);
`endif

    for (int k = 0; k < 16; k++) begin
      ra   = $urandom;
      rb   = $urandom;
      keep = (k != 15) && ($urandom_range(0, 2) == 0);
      do_op(ra, rb, $urandom_range(0, 1) == 1, $urandom_range(0, 3), keep,
            $urandom_range(0, 3) == 0);
    end
    bus.valid_data = 1'b0;

    // Abort mid-calculation: pending result is dropped, outputs clear at once.
    bus.a = 32'd77;
    bus.b = 32'd99;
    set_sop(1'b0);
    bus.valid_data = 1'b1;
    @(negedge clk);
    bus.valid_data = 1'b0;
    $display("abort: a=%h b=%h reset at CALC step 10", 32'd77, 32'd99);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_done", PW'(bus.Done_Flag), PW'(0));
    check("abort_busy", PW'(bus.busy), PW'(0));
    check("abort_producto", bus.producto, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_op(32'd1000, 32'd3000, 1'b0, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", PW'(sb_q.size()), PW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
